sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single synchronous-read SRAM port between the instruction-fetch requester and the load/store requester of the CPU pipeline. It arbitrates requests, builds byte write strobes and replicated write data, and tracks the one outstanding access. Responses are routed back to the owner one cycle after issue. It sits between the IF/MEM stages and the SRAM interface and replaces direct stage-to-SRAM wiring.

## Interface
- No parameters; widths fixed at 32-bit address/data, 4-bit strobe.
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address (word aligned)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  3  ACCESS_SZ_BYTE / _HALF / _WORD
- data_addr  in  32  byte address
- data_wdata  in  32  store data, right-aligned
- data_addr_ok  out  1  load/store accepted this cycle
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  32  load data (raw word, not extended)
- data_ale  out  1  misaligned access; valid with data_data_ok
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

## Operation
- Issue stage (combinational): grant at most one requester per cycle; grant asserts that requester's addr_ok and drives sram_en=1 with its address; addr_ok is the only acceptance signal, requesters hold req/addr/wdata until it.
- Default arbitration: fixed priority, data over inst.
- Response register: {pend_valid, pend_owner, pend_ale}, loaded on every grant, cleared when no grant.
- Response cycle: pend_valid drives owner's data_ok=1; owner's rdata = sram_rdata; non-owner rdata = 0; both rdata = 0 when pend_valid=0.
- Store strobes: WORD 1111; HALF 0011<<addr[1:0]; BYTE 0001<<addr[1:0]; wdata replicated (half x2, byte x4). Loads and fetches: sram_we=0000.
- Misalignment: HALF with addr[0]=1 or WORD with addr[1:0]!=0 -> still granted, sram_we forced 0000, data_ale=1 with data_data_ok next cycle. Undefined data_size -> sram_we=0000, acknowledged, ale=0.
- Back-to-back: a new grant may issue in the same cycle as a data_ok; one access per cycle sustained.
- Reset: rst_n=0 clears response register at the clock edge; while rst_n=0 all outputs forced 0 (addr_ok, data_ok, ale, sram_en, sram_we, rdata, sram_addr, sram_wdata). A pending access at reset never produces data_ok.

## Timing
- addr_ok: same cycle as req (zero latency); data_ok: exactly 1 cycle after addr_ok.
- Max one outstanding access; throughput 1 access/cycle.
- No combinational path from sram_rdata to any addr_ok.
- Both req asserted, fixed priority: inst stalls until data_req drops.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration; a last_grant register (reset = inst, so data wins first conflict) makes the requester not granted last win simultaneous requests; single requester always granted.
- Undefined: fixed priority data over inst, no last_grant register.

## Structure
- Shared defs header: ACCESS_SZ_* codes (existing), owner encoding OWNER_INST/OWNER_DATA, strobe patterns.
- Sub-module sram_wstrb_gen: combinational {wr, size, addr[1:0], wdata} -> {we, wdata_rep, ale}; instantiated once in the issue path.

## Test plan
- Fetch addr 0x1C000000, sram_rdata 0x02C00421 next cycle -> inst_addr_ok cycle 0, inst_data_ok + inst_rdata=0x02C00421 cycle 1, data_data_ok=0.
- Store BYTE 0xAB at 0x1003 -> sram_we=1000, sram_wdata=0xABABABAB; HALF 0x1234 at 0x1002 -> we=1100, wdata=0x12341234.
- Simultaneous inst/data req 3 cycles: fixed -> data granted every cycle, inst none; with SRAM_ARB_RR_EN -> data, inst, data.
- Load WORD at 0x1002 -> sram_we=0000, data_data_ok=1 and data_ale=1 next cycle; no write occurs.
- Back-to-back loads 0x2000, 0x2004 -> data_ok in consecutive cycles, each rdata matching its address.
- rst_n=0 in cycle after a grant -> no data_ok, all outputs 0; first request after release behaves as from reset.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: access size codes,
// response owner encoding, byte strobe patterns and the response record.
package sram_port_arbiter_pkg;

   // Access size codes used by the load/store unit
   localparam logic [2:0] ACCESS_SZ_BYTE = 3'b000;
   localparam logic [2:0] ACCESS_SZ_HALF = 3'b001;
   localparam logic [2:0] ACCESS_SZ_WORD = 3'b010;

   // Which requester owns the access currently in flight
   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   // Byte strobe patterns before shifting by the low address bits
   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_BYTE = 4'b0001;
   localparam logic [3:0] WSTRB_HALF = 4'b0011;
   localparam logic [3:0] WSTRB_WORD = 4'b1111;

   // Response register: one outstanding access at most
   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   ale;
   } pend_t;

endpackage

// File: rtl/sram_wstrb_gen.sv
// Store strobe / write-data replication / alignment check for one
// load/store request. Purely combinational.
module sram_wstrb_gen
   import sram_port_arbiter_pkg::*;
(
   input  logic        wr,
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  we,
   output logic [31:0] wdata_rep,
   output logic        ale
);

   // Decode size into strobes; misaligned or unknown sizes never write
   always_comb begin
      we        = WSTRB_NONE;
      wdata_rep = wdata;
      ale       = 1'b0;
      case (size)
         ACCESS_SZ_BYTE: begin
            wdata_rep = {4{wdata[7:0]}};
            if (wr) we = WSTRB_BYTE << addr_lo;
         end
         ACCESS_SZ_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            ale       = addr_lo[0];
            if (wr && !addr_lo[0]) we = WSTRB_HALF << addr_lo;
         end
         ACCESS_SZ_WORD: begin
            ale = |addr_lo;
            if (wr && (addr_lo == 2'b00)) we = WSTRB_WORD;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one synchronous-read SRAM port between instruction fetch
// and load/store. Data-over-inst fixed priority by default; define
// SRAM_ARB_RR_EN for round-robin arbitration with a last_grant register.
//
// Handshake: a requester raises req with its address/data and holds them
// until addr_ok is seen high in the same cycle (acceptance). The matching
// data_ok pulses exactly one cycle later; at most one access is in flight.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [2:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        data_ale,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   logic        gnt_inst;
   logic        gnt_data;
   logic        gnt_any;
   logic [3:0]  gen_we;
   logic [31:0] gen_wdata;
   logic        gen_ale;
   logic        resp_live;
   pend_t       pend_q;

   sram_wstrb_gen u_wstrb_gen (
      .wr        (data_wr),
      .size      (data_size),
      .addr_lo   (data_addr[1:0]),
      .wdata     (data_wdata),
      .we        (gen_we),
      .wdata_rep (gen_wdata),
      .ale       (gen_ale)
   );

`ifdef SRAM_ARB_RR_EN
   owner_e last_grant;

   // Remember who won last so the other side wins the next conflict
   always_ff @(posedge clk) begin
      if (!rst_n)        last_grant <= OWNER_INST;
      else if (gnt_data) last_grant <= OWNER_DATA;
      else if (gnt_inst) last_grant <= OWNER_INST;
   end

   // Round-robin grant on conflict, lone requester always granted
   always_comb begin
      gnt_data = 1'b0;
      gnt_inst = 1'b0;
      if (rst_n) begin
         if (data_req && inst_req) begin
            gnt_data = (last_grant == OWNER_INST);
            gnt_inst = (last_grant == OWNER_DATA);
         end else begin
            gnt_data = data_req;
            gnt_inst = inst_req;
         end
      end
   end
`else
   // Fixed priority grant: load/store beats fetch
   always_comb begin
      gnt_data = 1'b0;
      gnt_inst = 1'b0;
      if (rst_n) begin
         gnt_data = data_req;
         gnt_inst = inst_req && !data_req;
      end
   end
`endif

   assign gnt_any = gnt_data | gnt_inst;

   // Track the single in-flight access; reloaded on every cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q <= '{valid: 1'b0, owner: OWNER_INST, ale: 1'b0};
      end else begin
         pend_q.valid <= gnt_any;
         pend_q.owner <= gnt_data ? OWNER_DATA : OWNER_INST;
         pend_q.ale   <= gnt_data & gen_ale;
      end
   end

   // Issue side: the granted requester drives the SRAM port
   assign inst_addr_ok = gnt_inst;
   assign data_addr_ok = gnt_data;
   assign sram_en      = gnt_any;
   assign sram_addr    = gnt_data ? data_addr : (gnt_inst ? inst_addr : 32'h0);
   assign sram_we      = gnt_data ? gen_we    : WSTRB_NONE;
   assign sram_wdata   = gnt_data ? gen_wdata : 32'h0;

   // Response side: rst_n masks a response left over from before reset
   assign resp_live    = rst_n & pend_q.valid;
   assign inst_data_ok = resp_live & (pend_q.owner == OWNER_INST);
   assign data_data_ok = resp_live & (pend_q.owner == OWNER_DATA);
   assign data_ale     = data_data_ok & pend_q.ale;
   assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
   assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM, a
// rule-level reference model and literal spot checks at key cycles.
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [2:0]  data_size = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic        data_addr_ok, data_data_ok, data_ale;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = '0;

   int n_cmp = 0;
   int n_mis = 0;

   sram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata), .data_ale(data_ale),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural SRAM ----------------
   logic [31:0] mem [bit [29:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'hA5A50000;
   endfunction

   // Read returns the old word; byte lanes written afterwards
   always @(posedge clk) begin
      logic [31:0] w;
      if (sram_en) begin
         w = mem_rd(sram_addr);
         sram_rdata <= w;
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
         mem[sram_addr[31:2]] = w;
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit          is_data;
      bit          ale;
      logic [31:0] rdata;
   } resp_t;

   resp_t exp_q[$];
   resp_t nxt_resp;
   bit    nxt_valid = 0;
   bit    last_data = 0;   // round-robin memory: 1 = data won last
   bit    nxt_last  = 0;
   bit    running   = 0;

   // Check every cycle on the falling edge, inputs are stable by then
   always @(negedge clk) begin
      bit          gd, gi, mis, has;
      int          lo;
      logic [3:0]  ewe;
      logic [31:0] ewd, eaddr;
      resp_t       r;
      if (running) begin
         gd = 0; gi = 0;
         if (rst_n) begin
            if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
               gd = !last_data;
`else
               gd = 1;
`endif
               gi = !gd;
            end else begin
               gd = data_req;
               gi = inst_req;
            end
         end
         lo  = int'(data_addr[1:0]);
         mis = (data_size == ACCESS_SZ_HALF && (lo % 2) != 0) ||
               (data_size == ACCESS_SZ_WORD && lo != 0);
         ewe = 4'b0000;
         ewd = data_wdata;
         if (data_size == ACCESS_SZ_BYTE) begin
            ewe = 4'(2 ** lo);
            ewd = {24'h0, data_wdata[7:0]} * 32'h01010101;
         end else if (data_size == ACCESS_SZ_HALF) begin
            ewe = 4'(3 * (2 ** lo));
            ewd = {16'h0, data_wdata[15:0]} * 32'h00010001;
         end else if (data_size == ACCESS_SZ_WORD) begin
            ewe = 4'hF;
         end
         if (!data_wr || mis) ewe = 4'b0000;
         if (!gd) begin ewe = 4'b0000; ewd = 32'h0; end
         eaddr = gd ? data_addr : (gi ? inst_addr : 32'h0);

         chk("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, gi});
         chk("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, gd});
         chk("sram_en",      {31'h0, sram_en},      {31'h0, gd | gi});
         chk("sram_addr",    sram_addr,  eaddr);
         chk("sram_we",      {28'h0, sram_we}, {28'h0, ewe});
         chk("sram_wdata",   sram_wdata, ewd);

         has = rst_n && (exp_q.size() > 0);
         r   = has ? exp_q[0] : '{0, 0, 32'h0};
         chk("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, has && !r.is_data});
         chk("data_data_ok", {31'h0, data_data_ok}, {31'h0, has && r.is_data});
         chk("data_ale",     {31'h0, data_ale},     {31'h0, has && r.is_data && r.ale});
         chk("inst_rdata",   inst_rdata, (has && !r.is_data) ? r.rdata : 32'h0);
         chk("data_rdata",   data_rdata, (has && r.is_data)  ? r.rdata : 32'h0);

         nxt_valid = gd || gi;
         nxt_resp  = '{gd, gd && mis, mem_rd(eaddr)};
         nxt_last  = gd ? 1'b1 : (gi ? 1'b0 : last_data);
      end
   end

   // Retire last response and record the one issued this cycle
   always @(posedge clk) begin
      if (running) begin
         exp_q.delete();
         if (!rst_n) begin
            last_data = 0;
         end else begin
            if (nxt_valid) exp_q.push_back(nxt_resp);
            last_data = nxt_last;
         end
         nxt_valid = 0;
      end
   end

   // ---------------- driver ----------------
   typedef struct {
      logic        rst_n;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwr;
      logic [2:0]  dsz;
      logic [31:0] daddr;
      logic [31:0] dwdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rn, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [2:0] ds,
                      input logic [31:0] da, input logic [31:0] dd);
      vecs.push_back('{rn, ir, ia, dr, dw, ds, da, dd});
   endtask

   task automatic apply(input vec_t v);
      rst_n      = v.rst_n;
      inst_req   = v.ireq;
      inst_addr  = v.iaddr;
      data_req   = v.dreq;
      data_wr    = v.dwr;
      data_size  = v.dsz;
      data_addr  = v.daddr;
      data_wdata = v.dwdata;
   endtask

   // Literal expectations at chosen cycles, independent of the model
   task automatic pins(input int i);
      case (i)
         0:  begin chk("pin0 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
                   chk("pin0 sram_en", {31'h0, sram_en}, 32'h0); end
         2:  begin chk("pin2 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
                   chk("pin2 sram_addr", sram_addr, 32'h1C000000); end
         3:  begin chk("pin3 inst_data_ok", {31'h0, inst_data_ok}, 32'h1);
                   chk("pin3 inst_rdata", inst_rdata, 32'h02C00421);
                   chk("pin3 data_data_ok", {31'h0, data_data_ok}, 32'h0); end
         4:  begin chk("pin4 sram_we", {28'h0, sram_we}, 32'h8);
                   chk("pin4 sram_wdata", sram_wdata, 32'hABABABAB); end
         5:  begin chk("pin5 sram_we", {28'h0, sram_we}, 32'hC);
                   chk("pin5 sram_wdata", sram_wdata, 32'h12341234); end
`ifdef SRAM_ARB_RR_EN
         8:  chk("pin8 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
         9:  begin chk("pin9 data_addr_ok", {31'h0, data_addr_ok}, 32'h0);
                   chk("pin9 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1); end
         10: chk("pin10 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
`else
         8:  chk("pin8 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
         9:  begin chk("pin9 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
                   chk("pin9 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0); end
         10: chk("pin10 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
`endif
         11: begin chk("pin11 sram_we", {28'h0, sram_we}, 32'h0);
                   chk("pin11 data_addr_ok", {31'h0, data_addr_ok}, 32'h1); end
         12: begin chk("pin12 data_data_ok", {31'h0, data_data_ok}, 32'h1);
                   chk("pin12 data_ale", {31'h0, data_ale}, 32'h1); end
         13: begin chk("pin13 data_rdata", data_rdata, 32'hCAFEF00D);
                   chk("pin13 data_ale", {31'h0, data_ale}, 32'h0); end
         14: begin chk("pin14 data_rdata", data_rdata, 32'hA5A52004);
                   chk("pin14 sram_we", {28'h0, sram_we}, 32'h0); end
         15: begin chk("pin15 data_data_ok", {31'h0, data_data_ok}, 32'h1);
                   chk("pin15 data_ale", {31'h0, data_ale}, 32'h0);
                   chk("pin15 sram_we", {28'h0, sram_we}, 32'h0); end
         16: chk("pin16 data_ale", {31'h0, data_ale}, 32'h1);
         17: begin chk("pin17 inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
                   chk("pin17 sram_en", {31'h0, sram_en}, 32'h0); end
         18: chk("pin18 data_addr_ok", {31'h0, data_addr_ok}, 32'h0);
         19: begin chk("pin19 inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
                   chk("pin19 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1); end
         20: begin chk("pin20 inst_data_ok", {31'h0, inst_data_ok}, 32'h1);
                   chk("pin20 inst_rdata", inst_rdata, 32'h02C00421); end
         22: chk("pin22 data_rdata", data_rdata, 32'h12341000);
         default: ;
      endcase
   endtask

   initial begin
      mem[30'h07000000] = 32'h02C00421;   // word at 0x1C000000
      //   rst  ireq iaddr         dreq wr  size            daddr         wdata
      add(1'b0, 1, 32'h1C000000, 0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 0
      add(1'b0, 0, 32'h0,        0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 1
      add(1'b1, 1, 32'h1C000000, 0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 2
      add(1'b1, 0, 32'h0,        0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 3
      add(1'b1, 0, 32'h0,        1, 1, ACCESS_SZ_BYTE, 32'h1003,     32'h000000AB); // 4
      add(1'b1, 0, 32'h0,        1, 1, ACCESS_SZ_HALF, 32'h1002,     32'h00001234); // 5
      add(1'b1, 0, 32'h0,        1, 1, ACCESS_SZ_WORD, 32'h2000,     32'hCAFEF00D); // 6
      add(1'b1, 1, 32'h1C000000, 0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 7
      add(1'b1, 1, 32'h1C000004, 1, 0, ACCESS_SZ_WORD, 32'h2004,     32'h0);        // 8
      add(1'b1, 1, 32'h1C000004, 1, 0, ACCESS_SZ_WORD, 32'h2004,     32'h0);        // 9
      add(1'b1, 1, 32'h1C000004, 1, 0, ACCESS_SZ_WORD, 32'h2004,     32'h0);        // 10
      add(1'b1, 0, 32'h0,        1, 0, ACCESS_SZ_WORD, 32'h1002,     32'h0);        // 11
      add(1'b1, 0, 32'h0,        1, 0, ACCESS_SZ_WORD, 32'h2000,     32'h0);        // 12
      add(1'b1, 0, 32'h0,        1, 0, ACCESS_SZ_WORD, 32'h2004,     32'h0);        // 13
      add(1'b1, 0, 32'h0,        1, 1, 3'b111,         32'h3000,     32'hFFFFFFFF); // 14
      add(1'b1, 0, 32'h0,        1, 1, ACCESS_SZ_HALF, 32'h1001,     32'h00005555); // 15
      add(1'b1, 1, 32'h1C000008, 0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 16
      add(1'b0, 0, 32'h0,        0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 17
      add(1'b0, 0, 32'h0,        1, 0, ACCESS_SZ_WORD, 32'h2000,     32'h0);        // 18
      add(1'b1, 1, 32'h1C000000, 0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 19
      add(1'b1, 0, 32'h0,        0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 20
      add(1'b1, 0, 32'h0,        1, 0, ACCESS_SZ_WORD, 32'h1000,     32'h0);        // 21
      add(1'b1, 0, 32'h0,        0, 0, ACCESS_SZ_WORD, 32'h0,        32'h0);        // 22

      apply(vecs[0]);
      running = 1;
      for (int i = 0; i < vecs.size(); i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
         end
         #2;
         pins(i);
      end
      @(posedge clk);
      #1;
      apply('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ACCESS_SZ_WORD, 32'h0, 32'h0});
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
